// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_pkg : shared widths, NOP encoding and FSM state type for fetch_unit
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_INST_W = 32;
  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_REDIR_PEND = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_if : ROM, pipeline-control and IF/ID signals of the fetch stage
// Optional FETCH_ALIGN_CHECK_EN adds id_excp_adel.  Rev 1.0
// ============================================================================
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              stall_if;
  logic              stall_id;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              id_excp_adel;
`endif

  modport master (
    output rom_ce, rom_addr, id_pc, id_inst, id_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output id_excp_adel,
`endif
    input  rom_inst, stall_if, stall_id, branch_flag, branch_target,
    input  flush, flush_pc
  );

  modport slave (
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    input  id_excp_adel,
`endif
    output rom_inst, stall_if, stall_id, branch_flag, branch_target,
    output flush, flush_pc
  );

endinterface : fetch_if
`default_nettype wire

// File: rtl/if_id_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with flush > hold > bubble > load
// Optional FETCH_ALIGN_CHECK_EN carries the address-error flag.  Rev 1.0
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic              hold,
  input  wire logic              bubble,
  input  wire logic [ADDR_W-1:0] in_pc,
  input  wire logic [INST_W-1:0] in_inst,
`ifdef FETCH_ALIGN_CHECK_EN
  input  wire logic              in_excp,
  output logic                   id_excp,
`endif
  output logic      [ADDR_W-1:0] id_pc,
  output logic      [INST_W-1:0] id_inst,
  output logic                   id_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || (bubble && !hold)) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(FETCH_NOP);
      id_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      id_excp  <= 1'b0;
`endif
    end else if (!hold) begin
      id_pc    <= in_pc;
      id_inst  <= in_inst;
      id_valid <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      id_excp  <= in_excp;
`endif
    end
  end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_unit : PC, redirect FSM and ROM drive for the instruction-fetch stage
// Optional FETCH_ALIGN_CHECK_EN: word-align redirect targets, flag AdEL.  Rev 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INST_W   = FETCH_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input wire logic clk,
  input wire logic rst,
  fetch_if.master  bus
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_tgt;
  logic              ce;
  logic              redir_take;
  logic [ADDR_W-1:0] redir_addr;

  function automatic logic [ADDR_W-1:0] fix_target(input logic [ADDR_W-1:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    return {a[ADDR_W-1:2], 2'b00};
`else
    return a;
`endif
  endfunction

  // A branch arriving while a redirect is pending supersedes the older target.
  always_comb begin
    redir_take = 1'b0;
    redir_addr = bus.branch_target;
    if (!bus.stall_if) begin
      if (state == S_RUN && bus.branch_flag) begin
        redir_take = 1'b1;
      end else if (state == S_REDIR_PEND) begin
        redir_take = 1'b1;
        redir_addr = bus.branch_flag ? bus.branch_target : pend_tgt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ce       <= 1'b0;
      pc       <= RESET_PC;
      pend_tgt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_RUN;
          ce    <= 1'b1;
        end
        S_RUN, S_REDIR_PEND: begin
          if (bus.flush) begin
            pc    <= fix_target(bus.flush_pc);
            state <= S_RUN;
          end else if (redir_take) begin
            pc    <= fix_target(redir_addr);
            state <= S_RUN;
          end else if (bus.branch_flag) begin
            pend_tgt <= bus.branch_target;
            state    <= S_REDIR_PEND;
          end else if (!bus.stall_if && state == S_RUN) begin
            pc <= pc + ADDR_W'(4);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_ce   = ce;
  assign bus.rom_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  // Marks the instruction fetched from a truncated target; cleared once latched.
  logic adel_flag;
  logic id_load;

  assign id_load = ce && !bus.flush && !bus.stall_id && !bus.stall_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adel_flag <= 1'b0;
    end else if (ce && bus.flush) begin
      adel_flag <= |bus.flush_pc[1:0];
    end else if (redir_take) begin
      adel_flag <= |redir_addr[1:0];
    end else if (id_load) begin
      adel_flag <= 1'b0;
    end
  end
`endif

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .hold     (bus.stall_id),
    .bubble   (bus.stall_if || !ce),
    .in_pc    (pc),
    .in_inst  (bus.rom_inst),
`ifdef FETCH_ALIGN_CHECK_EN
    .in_excp  (adel_flag),
    .id_excp  (bus.id_excp_adel),
`endif
    .id_pc    (bus.id_pc),
    .id_inst  (bus.id_inst),
    .id_valid (bus.id_valid)
  );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table, misalignment sequence, async reset
// and randomized run against a rule-level reference model.  Rev 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign bus.rom_inst = rom_word(bus.rom_addr);

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    return a & 32'hFFFF_FFFC;
`else
    return a;
`endif
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic sif, input logic sid, input logic br,
                        input logic [31:0] tgt, input logic fl, input logic [31:0] fpc);
    bus.stall_if      = sif;
    bus.stall_id      = sid;
    bus.branch_flag   = br;
    bus.branch_target = tgt;
    bus.flush         = fl;
    bus.flush_pc      = fpc;
  endtask

  // Reference model: fetch rules applied per clock edge
  logic        m_ce, m_pv, m_v, m_flag, m_adel;
  logic [31:0] m_pc, m_pt, m_ipc, m_inst;

  task automatic model_reset();
    m_ce = 0; m_pc = 0; m_pv = 0; m_pt = 0;
    m_ipc = 0; m_inst = 0; m_v = 0; m_flag = 0; m_adel = 0;
  endtask

  task automatic model_step();
    logic sif, sid, br, fl, take;
    logic [31:0] t;
    sif = bus.stall_if; sid = bus.stall_id; br = bus.branch_flag; fl = bus.flush;
    t = '0; take = 0;
    if (!m_ce) begin
      m_ce = 1;
      return;
    end
    if (fl || (!sid && sif)) begin
      m_ipc = 0; m_inst = 0; m_v = 0; m_adel = 0;
    end else if (!sid) begin
      m_ipc = m_pc; m_inst = rom_word(m_pc); m_v = 1; m_adel = m_flag; m_flag = 0;
    end
    if (fl) begin
      m_pv = 0; t = bus.flush_pc; take = 1;
    end else if (!sif && (m_pv || br)) begin
      t = br ? bus.branch_target : m_pt; m_pv = 0; take = 1;
    end else if (br) begin
      m_pv = 1; m_pt = bus.branch_target;
    end else if (!sif) begin
      m_pc = m_pc + 32'd4;
    end
    if (take) begin
      m_pc = align(t);
      m_flag = |t[1:0];
    end
  endtask

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d rom_ce", cyc),   32'(bus.rom_ce),   32'(m_ce));
    check($sformatf("rnd%0d rom_addr", cyc), bus.rom_addr,      m_pc);
    check($sformatf("rnd%0d id_valid", cyc), 32'(bus.id_valid), 32'(m_v));
    check($sformatf("rnd%0d id_pc", cyc),    bus.id_pc,         m_ipc);
    check($sformatf("rnd%0d id_inst", cyc),  bus.id_inst,       m_inst);
`ifdef FETCH_ALIGN_CHECK_EN
    check($sformatf("rnd%0d id_excp_adel", cyc), 32'(bus.id_excp_adel), 32'(m_adel));
`endif
  endtask

  typedef struct {
    logic        sif, sid, br;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] fpc;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic sif, input logic sid, input logic br,
                              input logic [31:0] tgt, input logic fl, input logic [31:0] fpc,
                              input logic [31:0] addr, input logic v, input logic [31:0] ipc);
    vec_t r;
    r.sif = sif; r.sid = sid; r.br = br; r.tgt = tgt; r.fl = fl; r.fpc = fpc;
    r.addr = addr; r.v = v; r.ipc = ipc;
    return r;
  endfunction

  initial begin
    logic [31:0] t, exp_inst, mis_pc;

    //          sif sid br tgt           fl fpc    addr          v  ipc
    tbl[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h4,        1, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h8,        1, 32'h4);
    tbl[3]  = mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h8,        0, 32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h8,        0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'hC,        1, 32'h8);
    tbl[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h10,       1, 32'hC);
    tbl[7]  = mk(0, 0, 1, 32'h40,       0, 32'h0, 32'h40,       1, 32'h10);
    tbl[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h44,       1, 32'h40);
    tbl[9]  = mk(1, 0, 1, 32'h100,      0, 32'h0, 32'h44,       0, 32'h0);
    tbl[10] = mk(1, 0, 0, 32'h0,        0, 32'h0, 32'h44,       0, 32'h0);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h100,      1, 32'h44);
    tbl[12] = mk(0, 1, 0, 32'h0,        0, 32'h0, 32'h104,      1, 32'h44);
    tbl[13] = mk(1, 0, 1, 32'h200,      0, 32'h0, 32'h104,      0, 32'h0);
    tbl[14] = mk(1, 1, 1, 32'h300,      1, 32'h80, 32'h80,      0, 32'h0);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h84,       1, 32'h80);
    tbl[16] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 1, 32'h84);
    tbl[17] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h0,        1, 32'hFFFF_FFFC);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h4,        1, 32'h0);
    tbl[19] = mk(1, 0, 1, 32'h300,      0, 32'h0, 32'h4,        0, 32'h0);
    tbl[20] = mk(1, 0, 1, 32'h400,      0, 32'h0, 32'h4,        0, 32'h0);
    tbl[21] = mk(0, 0, 0, 32'h0,        0, 32'h0, 32'h400,      1, 32'h4);

    set_in(0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset rom_ce",   32'(bus.rom_ce),   32'h0);
    check("reset rom_addr", bus.rom_addr,      32'h0);
    check("reset id_valid", 32'(bus.id_valid), 32'h0);
    check("reset id_pc",    bus.id_pc,         32'h0);
    check("reset id_inst",  bus.id_inst,       32'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].sif, tbl[i].sid, tbl[i].br, tbl[i].tgt, tbl[i].fl, tbl[i].fpc);
      @(posedge clk);
      @(negedge clk);
      exp_inst = tbl[i].v ? rom_word(tbl[i].ipc) : 32'h0;
      check($sformatf("vec%0d rom_ce", i),   32'(bus.rom_ce),   32'h1);
      check($sformatf("vec%0d rom_addr", i), bus.rom_addr,      tbl[i].addr);
      check($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), 32'(tbl[i].v));
      check($sformatf("vec%0d id_pc", i),    bus.id_pc,         tbl[i].ipc);
      check($sformatf("vec%0d id_inst", i),  bus.id_inst,       exp_inst);
    end

    // Misaligned branch target 0x42 from pc=0x400
`ifdef FETCH_ALIGN_CHECK_EN
    mis_pc = 32'h40;
`else
    mis_pc = 32'h42;
`endif
    set_in(0, 0, 1, 32'h42, 0, 32'h0);
    @(posedge clk); @(negedge clk);
    check("mis rom_addr", bus.rom_addr, mis_pc);
    check("mis slot id_pc", bus.id_pc, 32'h400);
    set_in(0, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); @(negedge clk);
    check("mis id_pc", bus.id_pc, mis_pc);
    check("mis id_inst", bus.id_inst, rom_word(mis_pc));
    check("mis next addr", bus.rom_addr, mis_pc + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis id_excp_adel set", 32'(bus.id_excp_adel), 32'h1);
`endif
    @(posedge clk); @(negedge clk);
    check("mis follow id_pc", bus.id_pc, mis_pc + 32'd4);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis id_excp_adel clear", 32'(bus.id_excp_adel), 32'h0);
`endif

    // Pending redirect then asynchronous reset between clock edges
    set_in(1, 0, 1, 32'h600, 0, 32'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst rom_ce",   32'(bus.rom_ce),   32'h0);
    check("async rst rom_addr", bus.rom_addr,      32'h0);
    check("async rst id_valid", 32'(bus.id_valid), 32'h0);
    check("async rst id_pc",    bus.id_pc,         32'h0);
    set_in(0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); model_step(); @(negedge clk);
    check("after rst rom_addr", bus.rom_addr, 32'h0);
    @(posedge clk); model_step(); @(negedge clk);
    check("after rst pend lost", bus.rom_addr, 32'h4);

    for (int c = 0; c < 600; c++) begin
      t = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, t,
             $urandom_range(0, 15) == 0, t ^ 32'h0000_1000);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_model(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
